// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search controller: walks candidate keys, drives the decrypt core
// and byte checker handshakes. Optional attempt counter under RC4_KEY_SEARCH_ATTEMPT_CNT_EN.
module rc4_key_search_ctrl #(
    parameter int unsigned MSG_LEN         = 32,
    parameter logic [23:0] KEY_FIRST       = 24'h000000,
    parameter logic [23:0] KEY_LAST        = 24'h3FFFFF,
    parameter int unsigned VERDICT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        search_start,
    output logic [23:0] secret_key,
    output logic        crack_start,
    input  logic        byte_ready,
    output logic        byte_resume,
    output logic        check_start,
    input  logic        byte_valid,
    input  logic        new_key,
    output logic [7:0]  byte_idx,
    output logic        busy,
    output logic        key_found,
`ifdef RC4_KEY_SEARCH_ATTEMPT_CNT_EN
    output logic [23:0] keys_tried,
`endif
    output logic        key_exhausted
);

    localparam int TW = $clog2(VERDICT_TIMEOUT + 2);
    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    if (KEY_FIRST > KEY_LAST) begin : g_bad_key_range
        $error("rc4_key_search_ctrl: KEY_FIRST must not exceed KEY_LAST");
    end
    if (MSG_LEN < 1 || MSG_LEN > 255) begin : g_bad_msg_len
        $error("rc4_key_search_ctrl: MSG_LEN must be 1..255");
    end

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_BYTE, CHECK, WAIT_VERDICT,
        NEXT_BYTE, NEXT_KEY, FOUND, EXHAUSTED
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic [23:0]   key_d;
    logic [7:0]    idx_d;
    logic          crack_d, resume_d, check_d, busy_d, found_d, exh_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        key_d     = secret_key;
        idx_d     = byte_idx;
        tmo_cnt_d = tmo_cnt;
        crack_d   = 1'b0;
        resume_d  = 1'b0;
        check_d   = 1'b0;
        found_d   = key_found;
        exh_d     = key_exhausted;
        case (state)
            IDLE, FOUND, EXHAUSTED: begin
                if (search_start) begin
                    state_d = LOAD;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    key_d   = KEY_FIRST;
                    idx_d   = 8'd0;
                end
            end
            LOAD: begin
                crack_d = 1'b1;
                state_d = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                // byte_ready may still show the previous byte while our restart/advance
                // pulse is on the wire; the core only reacts at the following edge.
                if (byte_ready && !crack_start && !byte_resume) state_d = CHECK;
            end
            CHECK: begin
                check_d   = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_VERDICT;
            end
            WAIT_VERDICT: begin
                if (new_key)                            state_d = NEXT_KEY;
                else if (byte_valid)                    state_d = NEXT_BYTE;
                else if (tmo_cnt == TW'(VERDICT_TIMEOUT)) state_d = NEXT_KEY;
                else                                    tmo_cnt_d = tmo_cnt + TW'(1);
            end
            NEXT_BYTE: begin
                if (byte_idx == LAST_IDX) begin
                    state_d = FOUND;
                    found_d = 1'b1;
                end else begin
                    idx_d    = byte_idx + 8'd1;
                    resume_d = 1'b1;
                    state_d  = WAIT_BYTE;
                end
            end
            NEXT_KEY: begin
                if (secret_key == KEY_LAST) begin
                    state_d = EXHAUSTED;
                    exh_d   = 1'b1;
                end else begin
                    key_d   = secret_key + 24'd1;
                    idx_d   = 8'd0;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = !(state_d inside {IDLE, FOUND, EXHAUSTED});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            secret_key    <= KEY_FIRST;
            byte_idx      <= 8'd0;
            tmo_cnt       <= '0;
            crack_start   <= 1'b0;
            byte_resume   <= 1'b0;
            check_start   <= 1'b0;
            busy          <= 1'b0;
            key_found     <= 1'b0;
            key_exhausted <= 1'b0;
        end else begin
            secret_key    <= key_d;
            byte_idx      <= idx_d;
            tmo_cnt       <= tmo_cnt_d;
            crack_start   <= crack_d;
            byte_resume   <= resume_d;
            check_start   <= check_d;
            busy          <= busy_d;
            key_found     <= found_d;
            key_exhausted <= exh_d;
        end
    end

`ifdef RC4_KEY_SEARCH_ATTEMPT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            keys_tried <= '0;
        else if (state inside {IDLE, FOUND, EXHAUSTED} && search_start)
            keys_tried <= '0;
        else if (state == LOAD && keys_tried != 24'hFFFFFF)
            keys_tried <= keys_tried + 24'd1;
    end
`endif

endmodule
